// File: rtl/camkey_pkg.sv
// camkey_query_ctrl shared types and helpers.
// FSM states, default widths and key-pair decode.
package camkey_pkg;

    localparam int NUM_PAIRS_DEF  = 6;
    localparam int KEY_W          = 2 * NUM_PAIRS_DEF;
    localparam int PI_W_DEF       = 36;
    localparam int PO_W_DEF       = 7;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int MAX_KEY_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_APPLY,
        ST_RESP
    } state_e;

    // Pair i value: even bit is the high bit.
    function automatic logic [1:0] pair_val(
        input logic [MAX_KEY_W-1:0] key,
        input int unsigned          i
    );
        return {key[2*i], key[2*i+1]};
    endfunction

endpackage

// File: rtl/camkey_query_ctrl_pair_checker.sv
// Combinational legality check of every select pair.
// Ports: key (select bits), allow_mask (4 bits/pair), all_legal.
module camkey_pair_checker
    import camkey_pkg::*;
#(
    parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
    input  logic [2*NUM_PAIRS-1:0] key,
    input  logic [4*NUM_PAIRS-1:0] allow_mask,
    output logic                   all_legal
);

    logic [MAX_KEY_W-1:0] key_ext;
    logic [1:0]           v;

    always_comb begin
        key_ext   = MAX_KEY_W'(key);
        all_legal = 1'b1;
        v         = 2'd0;
        for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
            v = pair_val(key_ext, i);
            if (!allow_mask[4*i+{30'd0, v}]) begin
                all_legal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/camkey_query_ctrl.sv
// Key loader and oracle query sequencer for camouflaged c432.
// Ports: key_* serial key load, s_out committed selects,
// q_* query in, pi_out/po_in netlist, r_* response out.
module camkey_query_ctrl
    import camkey_pkg::*;
#(
    parameter int NUM_PAIRS  = NUM_PAIRS_DEF,
    parameter int PI_W       = PI_W_DEF,
    parameter int PO_W       = PO_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter logic [4*NUM_PAIRS-1:0] ALLOW_MASK = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid,
    input  logic                   key_bit,
    output logic                   key_ready,
    output logic                   key_done,
    output logic                   key_err,
    output logic                   key_ok,
    output logic [2*NUM_PAIRS-1:0] s_out,
    input  logic                   q_valid,
    input  logic [PI_W-1:0]        q_pattern,
    output logic                   q_ready,
    output logic [PI_W-1:0]        pi_out,
    input  logic [PO_W-1:0]        po_in,
    output logic                   r_valid,
    output logic [PO_W-1:0]        r_data,
    input  logic                   r_ready
);

    localparam int KW  = 2 * NUM_PAIRS;
    localparam int BCW = $clog2(KW + 1);
    localparam int SCW = $clog2(SETTLE_CYC + 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   shift_q, shift_d;
    logic [KW-1:0]   s_q, s_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic            key_ok_q, key_ok_d;
    logic            key_done_q, key_done_d;
    logic            key_err_q, key_err_d;
    logic [PI_W-1:0] pi_q, pi_d;
    logic            r_valid_q, r_valid_d;
    logic [PO_W-1:0] r_data_q, r_data_d;
    logic            all_legal;

    camkey_pair_checker #(
        .NUM_PAIRS (NUM_PAIRS)
    ) u_checker (
        .key        (shift_q),
        .allow_mask (ALLOW_MASK),
        .all_legal  (all_legal)
    );

    // Key bits win over a same-cycle query.
    assign key_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign q_ready   = (state_q == ST_IDLE) && key_ok_q && !key_valid;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        settle_d   = settle_q;
        key_ok_d   = key_ok_q;
        key_done_d = 1'b0;
        key_err_d  = 1'b0;
        pi_d       = pi_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d   = ST_LOAD;
                    key_ok_d  = 1'b0;
                    shift_d   = {{(KW-1){1'b0}}, key_bit};
                    bit_cnt_d = BCW'(1);
                end else if (q_valid && key_ok_q) begin
                    state_d  = ST_APPLY;
                    pi_d     = q_pattern;
                    settle_d = '0;
                end
            end
            ST_LOAD: begin
                if (key_valid) begin
                    shift_d   = {shift_q[KW-2:0], key_bit};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(KW - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = '0;
                key_done_d = 1'b1;
                if (all_legal) begin
                    s_d      = shift_q;
                    key_ok_d = 1'b1;
                end else begin
                    key_err_d = 1'b1;
                end
            end
            ST_APPLY: begin
                if (settle_q == SCW'(SETTLE_CYC - 1)) begin
                    state_d   = ST_RESP;
                    r_data_d  = po_in;
                    r_valid_d = 1'b1;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            ST_RESP: begin
                if (r_ready) begin
                    state_d   = ST_IDLE;
                    r_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            settle_q   <= '0;
            key_ok_q   <= 1'b0;
            key_done_q <= 1'b0;
            key_err_q  <= 1'b0;
            pi_q       <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            settle_q   <= settle_d;
            key_ok_q   <= key_ok_d;
            key_done_q <= key_done_d;
            key_err_q  <= key_err_d;
            pi_q       <= pi_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
        end
    end

    assign key_done = key_done_q;
    assign key_err  = key_err_q;
    assign key_ok   = key_ok_q;
    assign s_out    = s_q;
    assign pi_out   = pi_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;

endmodule
